sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO; the next generation of the team's FIFO buffer line.
- Generalised in data width and depth. Adds occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode.
- Used wherever producer and consumer share one clock domain.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 4, address width; depth = 2**ADDR_W (default 16 entries).
- AF_THRESH, 12, almost_full asserts when count >= AF_THRESH (1..depth).
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH (0..depth-1).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- w_en  input  1  write request.
- data_in  input  DATA_W  write data.
- r_en  input  1  read request (FWFT=1: pop/acknowledge of the head word).
- data_out  output  DATA_W  read data.
- data_valid  output  1  data_out holds valid read data.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  ADDR_W+1  current occupancy, 0..depth.
- overflow  output  1  one-cycle pulse: write requested while full.
- underflow  output  1  one-cycle pulse: read requested while empty.

Behaviour:
- Storage: 2**ADDR_W x DATA_W array, written on clk. Array contents are not reset.
- Pointers: wptr and rptr are ADDR_W+1 bits, binary. The low ADDR_W bits address the array. The MSB is the wrap bit; both pointers wrap naturally modulo 2**(ADDR_W+1).
- count = wptr - rptr, computed modulo 2**(ADDR_W+1), so it reaches depth without aliasing.
- full, empty, almost_full and almost_empty are combinational from the registered pointers. They reflect an operation in the cycle after the accepting edge.
- Write acceptance: wr_ok = w_en & !full. On wr_ok, mem[wptr] <= data_in and wptr increments.
- Read acceptance: rd_ok = r_en & !empty. On rd_ok, rptr increments.
- Acceptance is judged on the flags before the edge:
  - Simultaneous w_en and r_en while full: only the read is accepted; count decrements by 1 and overflow pulses.
  - Simultaneous w_en and r_en while empty: only the write is accepted; count increments by 1 and underflow pulses.
  - Simultaneous accepted read and write otherwise: count unchanged, both pointers advance.
- overflow = registered (w_en & full); underflow = registered (r_en & empty). Each is high for exactly one cycle per offending request and never sticky.
- FWFT=0 (standard read):
  - On rd_ok, data_out <= mem[rptr[ADDR_W-1:0]] and data_valid <= 1, i.e. 1-cycle read latency.
  - If no rd_ok, data_valid <= 0 and data_out holds its last value.
- FWFT=1 (first-word-fall-through):
  - data_out = mem[rptr] and data_valid = !empty, both combinational from registered state.
  - The first written word appears one cycle after its write edge.
  - r_en with data_valid consumes the head word; the next word is presented the following cycle.
- Reset (asynchronous assert):
  - wptr = rptr = 0, count = 0, empty = 1, almost_empty = 1.
  - full = 0, almost_full = 0 (given AF_THRESH >= 1).
  - data_out = 0, data_valid = 0, overflow = 0, underflow = 0.
  - Reset asserted mid-stream discards all stored words immediately. There is no recovery of in-flight data.
- Reset release: the FIFO operates from the first clock edge after deassertion.
- Wrap-around: after 2**ADDR_W writes, the address rolls over to 0 and the wrap bit toggles. full/empty must remain correct across any number of wraps.
- Constraints: AE_THRESH < AF_THRESH is required. Parameter values outside the ranges above are illegal and unsupported.

Test Plan:
- Reset then idle, default parameters -> empty=1, almost_empty=1, full=0, count=0, data_valid=0, data_out=0.
- FWFT=0: write 0x01..0x10 (16 words) -> full=1 and count=16 after the 16th edge. A 17th write -> overflow pulses once, count stays 16. Then 16 reads -> data_out sequence 0x01..0x10, each one cycle after r_en. Then a read with empty=1 -> underflow pulses once.
- Thresholds at defaults: fill one word per cycle -> almost_full first high at count=12. Drain one word per cycle -> almost_empty first high at count=4.
- Simultaneous w_en=r_en=1 for 40 cycles starting at count=8 -> count stays 8; output order preserved across two pointer wraps.
- Full and w_en=r_en=1 -> count 16->15, overflow=1 for one cycle. Empty and w_en=r_en=1 -> count 0->1, underflow=1 for one cycle.
- FWFT=1: write 0xA5 -> data_out=0xA5, data_valid=1 on the next cycle with no r_en. Assert reset while count=5 -> count=0, empty=1, data_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count,
// almost-full/almost-empty thresholds, overflow/underflow pulses and a
// selectable read mode (registered read or first-word-fall-through).
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   w_en/data_in  write request and write data
//   r_en          read request (FWFT=1: pop of the presented head word)
//   data_out      read data
//   data_valid    data_out holds valid read data
//   full/empty    count == depth / count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         occupancy, 0..depth
//   overflow      one-cycle pulse after a write request while full
//   underflow     one-cycle pulse after a read request while empty
module sync_fifo_param #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int AF_THRESH = 12,
   parameter int AE_THRESH = 4,
   parameter int FWFT      = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              w_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              r_en,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
   localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);
   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W:0]   wptr_q, wptr_d;
   logic [ADDR_W:0]   rptr_q, rptr_d;
   logic              overflow_q, underflow_q;
   logic              wr_ok, rd_ok;

   // The extra wrap bit lets the difference reach DEPTH without aliasing
   // to zero, so full and empty stay distinct across any number of wraps.
   assign count        = wptr_q - rptr_q;
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   // Acceptance is judged on the pre-edge flags, so a simultaneous
   // read+write on a full FIFO drops the write and on an empty FIFO
   // drops the read.
   assign wr_ok = w_en & ~full;
   assign rd_ok = r_en & ~empty;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (wr_ok) wptr_d = wptr_q + PTR_ONE;
      if (rd_ok) rptr_d = rptr_q + PTR_ONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         overflow_q  <= w_en & full;
         underflow_q <= r_en & empty;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wptr_q[ADDR_W-1:0]] <= data_in;
   end

   generate
      if (FWFT == 0) begin : g_std_read
         logic [DATA_W-1:0] dout_q;
         logic              dvalid_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               dout_q   <= '0;
               dvalid_q <= 1'b0;
            end else if (rd_ok) begin
               dout_q   <= mem_q[rptr_q[ADDR_W-1:0]];
               dvalid_q <= 1'b1;
            end else begin
               dvalid_q <= 1'b0;
            end
         end

         assign data_out   = dout_q;
         assign data_valid = dvalid_q;
      end else begin : g_fwft_read
         // Head word is presented straight from the array. It is forced to
         // zero while empty so the output is defined (zero) out of reset,
         // where the unreset array would otherwise show stale contents.
         assign data_out   = empty ? '0 : mem_q[rptr_q[ADDR_W-1:0]];
         assign data_valid = ~empty;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 4;

   logic       clk;
   logic       reset = 1'b0;
   logic       w_en, r_en;
   logic [7:0] data_in;

   logic [7:0] c0_data_out, c1_data_out;
   logic       c0_data_valid, c1_data_valid;
   logic       c0_full, c0_empty, c0_af, c0_ae, c0_ovf, c0_udf;
   logic       c1_full, c1_empty, c1_af, c1_ae, c1_ovf, c1_udf;
   logic [4:0] c0_count, c1_count;

   int checks = 0;
   int errors = 0;
   bit run    = 0;

   sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut0 (
      .clk(clk), .reset(reset), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(c0_data_out), .data_valid(c0_data_valid), .full(c0_full), .empty(c0_empty),
      .almost_full(c0_af), .almost_empty(c0_ae), .count(c0_count),
      .overflow(c0_ovf), .underflow(c0_udf));

   sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut1 (
      .clk(clk), .reset(reset), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(c1_data_out), .data_valid(c1_data_valid), .full(c1_full), .empty(c1_empty),
      .almost_full(c1_af), .almost_empty(c1_ae), .count(c1_count),
      .overflow(c1_ovf), .underflow(c1_udf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of stored words plus the registered outputs.
   logic [7:0] q[$];
   logic [7:0] m_dout0 = 8'h00;
   logic       m_dv0   = 1'b0;
   logic       m_ovf   = 1'b0;
   logic       m_udf   = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete();
         m_dout0 = 8'h00;
         m_dv0   = 1'b0;
         m_ovf   = 1'b0;
         m_udf   = 1'b0;
      end else begin
         int  sz;
         bit  wok, rok;
         sz    = q.size();
         m_ovf = w_en && (sz == DEPTH);
         m_udf = r_en && (sz == 0);
         wok   = w_en && (sz != DEPTH);
         rok   = r_en && (sz != 0);
         if (rok) begin
            m_dout0 = q.pop_front();
            m_dv0   = 1'b1;
         end else begin
            m_dv0 = 1'b0;
         end
         if (wok) q.push_back(data_in);
      end
   end

   always @(negedge clk) begin
      if (run) begin
         int sz;
         sz = q.size();
         chk("count0", c0_count, sz);
         chk("full0", c0_full, sz == DEPTH);
         chk("empty0", c0_empty, sz == 0);
         chk("af0", c0_af, sz >= AF);
         chk("ae0", c0_ae, sz <= AE);
         chk("ovf0", c0_ovf, m_ovf);
         chk("udf0", c0_udf, m_udf);
         chk("dout0", c0_data_out, m_dout0);
         chk("dv0", c0_data_valid, m_dv0);
         chk("count1", c1_count, sz);
         chk("full1", c1_full, sz == DEPTH);
         chk("empty1", c1_empty, sz == 0);
         chk("ovf1", c1_ovf, m_ovf);
         chk("udf1", c1_udf, m_udf);
         chk("dv1", c1_data_valid, sz != 0);
         chk("dout1", c1_data_out, (sz != 0) ? q[0] : 8'h00);
      end
   end

   task automatic drive(input logic w, input logic r, input logic [7:0] d);
      w_en    = w;
      r_en    = r;
      data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      w_en    = 1'b0;
      r_en    = 1'b0;
      data_in = 8'h00;
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_empty", c0_empty, 1);
      chk("rst_ae", c0_ae, 1);
      chk("rst_full", c0_full, 0);
      chk("rst_count", c0_count, 0);
      chk("rst_dv", c0_data_valid, 0);
      chk("rst_dout", c0_data_out, 0);
      chk("rst_dv1", c1_data_valid, 0);
      chk("rst_dout1", c1_data_out, 0);
      reset = 1'b0;
      run   = 1;
      drive(0, 0, 8'h00);

      // Fill with 0x01..0x10.
      for (int i = 1; i <= 16; i++) begin
         drive(1, 0, 8'(i));
         if (i == 1)  chk("fwft_first", c1_data_out, 8'h01);
         if (i == 11) chk("af_at11", c0_af, 0);
         if (i == 12) chk("af_at12", c0_af, 1);
      end
      chk("fill_count", c0_count, 16);
      chk("fill_full", c0_full, 1);
      drive(1, 0, 8'hFF);
      chk("ovf_pulse", c0_ovf, 1);
      chk("ovf_count", c0_count, 16);
      drive(0, 0, 8'h00);
      chk("ovf_clear", c0_ovf, 0);

      // Drain: data follows 1 cycle after r_en.
      for (int i = 1; i <= 16; i++) begin
         drive(0, 1, 8'h00);
         chk("rd_data", c0_data_out, 8'(i));
         chk("rd_valid", c0_data_valid, 1);
         if (i == 11) chk("ae_at5", c0_ae, 0);
         if (i == 12) chk("ae_at4", c0_ae, 1);
      end
      drive(0, 1, 8'h00);
      chk("udf_pulse", c0_udf, 1);
      chk("udf_dv", c0_data_valid, 0);
      drive(0, 0, 8'h00);
      chk("udf_clear", c0_udf, 0);

      // Simultaneous on empty: only the write lands.
      drive(1, 1, 8'h33);
      chk("emp_rw_count", c0_count, 1);
      chk("emp_rw_udf", c0_udf, 1);
      for (int i = 0; i < 15; i++) drive(1, 0, 8'($urandom));
      chk("refill_full", c0_full, 1);
      // Simultaneous on full: only the read lands.
      drive(1, 1, 8'h44);
      chk("full_rw_count", c0_count, 15);
      chk("full_rw_ovf", c0_ovf, 1);
      chk("full_rw_data", c0_data_out, 8'h33);
      drive(0, 0, 8'h00);
      chk("full_rw_ovf_clr", c0_ovf, 0);

      // Hold at 8 with concurrent read+write across pointer wraps.
      for (int i = 0; i < 7; i++) drive(0, 1, 8'h00);
      chk("start8", c0_count, 8);
      for (int i = 0; i < 40; i++) begin
         drive(1, 1, 8'($urandom));
         chk("steady8", c0_count, 8);
      end

      // Randomised traffic with varying write/read bias.
      for (int p = 0; p < 4; p++) begin
         int wp, rp;
         case (p)
            0: begin wp = 70; rp = 30; end
            1: begin wp = 30; rp = 70; end
            2: begin wp = 50; rp = 50; end
            default: begin wp = 90; rp = 90; end
         endcase
         for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 8'($urandom));
      end

      // FWFT presentation and asynchronous mid-stream reset.
      drive(0, 0, 8'h00);
      do_reset();
      drive(1, 0, 8'hA5);
      chk("fwft_a5", c1_data_out, 8'hA5);
      chk("fwft_a5_dv", c1_data_valid, 1);
      drive(0, 0, 8'h00);
      chk("fwft_hold", c1_data_out, 8'hA5);
      for (int i = 0; i < 4; i++) drive(1, 0, 8'(i + 8'h10));
      chk("pre_rst_count", c1_count, 5);
      reset = 1'b1;
      #1;
      chk("async_count1", c1_count, 0);
      chk("async_empty1", c1_empty, 1);
      chk("async_dv1", c1_data_valid, 0);
      chk("async_count0", c0_count, 0);
      chk("async_dout0", c0_data_out, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1, 0, 8'h5A);
      chk("post_rst_fwft", c1_data_out, 8'h5A);
      drive(0, 1, 8'h00);
      chk("post_rst_read", c0_data_out, 8'h5A);
      drive(0, 0, 8'h00);

      run = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
